fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares one write port of a downstream FIFO (DATA_BIT_SIZE wide, with full/almost-full flags) among N_REQ requesters.
- Grants whole bursts, terminated by req_last, using round-robin priority. The grant is locked for the duration of a burst.
- Starts a new burst only when the FIFO is not almost-full. Individual beats stall on full.
- Sits between the cache-miss/writeback request sources and the DRAM request FIFO.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_BIT_SIZE, 8, beat width; matches the FIFO data width.
- MAX_BURST, 8, maximum beats per grant before a forced release (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_BIT_SIZE  beats, packed; requester i occupies slice [i*DATA_BIT_SIZE +: DATA_BIT_SIZE]
- req_last  in  N_REQ  per-requester last beat of burst
- req_ready  out  N_REQ  per-requester beat accepted this cycle when valid&ready
- fifo_full  in  1  downstream FIFO full
- fifo_a_full  in  1  downstream FIFO almost-full
- fifo_write_en  out  1  FIFO write strobe
- fifo_write_data  out  DATA_BIT_SIZE  FIFO write data
- busy  out  1  a grant is held (state LOCKED)
- owner  out  $clog2(N_REQ)  index of current or last grantee
- burst_err  out  1  sticky: a burst was force-released at MAX_BURST

Behaviour:
- Reset values:
  - state=IDLE; req_ready=0; fifo_write_en=0; fifo_write_data=0; busy=0; owner=0; burst_err=0.
  - Priority pointer set to N_REQ-1, so requester 0 wins first.
  - Beat counter=0.
- State machine, two states:
  - IDLE:
    - If any req_valid && !fifo_a_full: pick the first valid requester scanning from ptr+1 with wrap.
    - Register owner=pick and beat counter=0, then go to LOCKED.
    - No beat is accepted in IDLE, so arbitration costs 1 cycle per burst.
    - If fifo_a_full, stay in IDLE even if requests are pending.
  - LOCKED:
    - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
    - A beat is accepted when req_valid[owner] && req_ready[owner].
    - fifo_write_en = beat accepted; fifo_write_data = req_data slice of owner. Both are combinational, 0-cycle latency.
    - When no beat is accepted, fifo_write_data is 0.
    - Each accepted beat increments the beat counter.
    - Accepted beat with req_last: go to IDLE and set ptr=owner.
    - Accepted beat without req_last, where the counter reaches MAX_BURST: go to IDLE, set ptr=owner, set burst_err=1.
    - The remaining beats of that requester re-arbitrate as a new burst.
    - Owner deasserting valid mid-burst: grant held indefinitely (no timeout); ready still reflects !fifo_full.
    - fifo_a_full is ignored in LOCKED; only fifo_full stalls beats.
- Boundaries:
  - fifo_full asserts mid-beat: ready drops the same cycle and the beat is held by the requester (valid must stay asserted).
  - Single requester repeatedly valid: it is re-granted after each IDLE cycle.
  - Round-robin: after owner k finishes, k is lowest priority for the next pick.
  - Pointer wrap: N_REQ-1 to 0.
  - Reset mid-burst: immediately IDLE, no write strobe in the reset cycle, partial burst abandoned, burst_err cleared.
- busy = (state==LOCKED). owner holds its value in IDLE.
- The beat counter is $clog2(MAX_BURST+1) bits and saturates, with no wrap.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - arb_state_t enum {IDLE, LOCKED};
  - localparams IDX_W=$clog2(N_REQ) and CNT_W=$clog2(MAX_BURST+1), supplied via package functions or the module.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: grant index, any_valid.
  - Instanced once in fifo_wr_arbiter.

Test Plan:
- Reset, then req_valid=4'b0001, 3-beat burst of data 0x11/0x22/0x33 with last on beat 3:
  - cycle 1 IDLE→LOCKED, owner=0;
  - fifo_write_en high 3 cycles with data 0x11,0x22,0x33;
  - busy drops after beat 3.
- All four requesters valid with 1-beat bursts:
  - grant order 0,1,2,3,0;
  - each write is preceded by exactly 1 idle arbitration cycle.
- fifo_a_full=1 in IDLE with req 1 valid: no grant, busy=0. Deassert fifo_a_full: owner=1 granted next cycle.
- Mid-burst fifo_full=1 for 3 cycles:
  - req_ready=0, fifo_write_en=0, grant held;
  - on release the same beat (data 0x5A) is written once.
- MAX_BURST=8, requester 2 sends 10 beats with no last:
  - forced release after beat 8, burst_err=1 (sticky);
  - requester 2 re-granted for the remaining 2 beats.
- Reset asserted mid-burst (after beat 2 of 4): next cycle busy=0, burst_err=0, no writes; after reset requester 0 has first priority.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  int unsigned      idx;
  logic [IDX_W-1:0] sel;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (32'(ptr) + 32'(i)) % 32'(N_REQ);
      sel = IDX_W'(idx);
      if (!any_valid && req[sel]) begin
        any_valid = 1'b1;
        grant     = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one downstream FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_BIT_SIZE = 8,
  parameter int MAX_BURST     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*DATA_BIT_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]               req_last,
  output logic [N_REQ-1:0]               req_ready,
  input  logic                           fifo_full,
  input  logic                           fifo_a_full,
  output logic                           fifo_write_en,
  output logic [DATA_BIT_SIZE-1:0]       fifo_write_data,
  output logic                           busy,
  output logic [$clog2(N_REQ)-1:0]       owner,
  output logic                           burst_err
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);

  arb_state_t               state;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         pick;
  logic                     any_valid;
  logic [CNT_W-1:0]         beat_cnt;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     cap_hit;
  logic                     accept;
  logic                     owner_last;
  logic [DATA_BIT_SIZE-1:0] owner_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  // Gating with reset keeps the reset cycle free of strobes even while LOCKED.
  assign accept     = !reset && (state == LOCKED) && req_valid[owner] && !fifo_full;
  assign owner_last = req_last[owner];
  assign owner_data = req_data[int'(owner)*DATA_BIT_SIZE +: DATA_BIT_SIZE];

  assign cnt_inc = (beat_cnt == CNT_W'(MAX_BURST)) ? beat_cnt : beat_cnt + 1'b1;
  assign cap_hit = (cnt_inc == CNT_W'(MAX_BURST));

  always_comb begin
    req_ready = '0;
    if (!reset && state == LOCKED) req_ready[owner] = !fifo_full;
  end

  assign fifo_write_en   = accept;
  assign fifo_write_data = accept ? owner_data : '0;
  assign busy            = (state == LOCKED);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      owner     <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid && !fifo_a_full) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            beat_cnt <= cnt_inc;
            if (owner_last || cap_hit) begin
              state <= IDLE;
              ptr   <= owner;
              if (!owner_last) burst_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: requester queues drive beats, a monitor checks every FIFO write.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int           owner;
    logic [W-1:0] data;
    int           gap;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_a_full;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_write_data;
  logic           busy;
  logic [1:0]     owner;
  logic           burst_err;

  beat_t        src_q[N][$];
  exp_t         exp_q[$];
  logic [N-1:0] hs;
  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           cyc      = 0;
  int           last_cyc = 0;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_BIT_SIZE(W), .MAX_BURST(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_a_full     (fifo_a_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .busy            (busy),
    .owner           (owner),
    .burst_err       (burst_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = src_q[i][0].data;
        req_last[i]        = src_q[i][0].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[r].push_back(b);
    refresh();
  endtask

  task automatic exp_push(input int o, input logic [W-1:0] d, input int gap);
    exp_t e;
    e.owner = o;
    e.data  = d;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) src_q[i].delete();
    refresh();
  endtask

  // Stimulus changes land 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    flush_sources();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Requester model: a beat leaves its queue when the handshake completed at the edge.
  always @(negedge clk) hs = req_valid & req_ready;
  always @(posedge clk) begin
    beat_t b;
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
    refresh();
  end

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (fifo_write_en) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: data=%0h owner=%0d, required no write (t=%0t)",
                 fifo_write_data, owner, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", fifo_write_data, e.data);
        check("wr_owner", owner, e.owner);
        if (e.gap != 0) check("wr_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    hs          = '0;
    reset       = 1'b1;
    fifo_full   = 1'b0;
    fifo_a_full = 1'b0;
    refresh();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_burst_err", burst_err, 0);
    check("rst_wr_en", fifo_write_en, 0);
    check("rst_wr_data", fifo_write_data, 0);
    check("rst_ready", req_ready, 0);

    // 3-beat burst from requester 0
    tick();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    exp_push(0, 8'h11, 0); exp_push(0, 8'h22, 1); exp_push(0, 8'h33, 1);
    @(negedge clk);
    check("t1_arb_busy", busy, 0);
    check("t1_arb_wr_data", fifo_write_data, 0);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_owner", owner, 0);
    repeat (3) @(negedge clk);
    check("t1_busy_drop", busy, 0);
    wait_drain("t1_drain", 10);

    // Four requesters with 1-beat bursts: order 0,1,2,3,0 with wrap
    do_reset();
    push(0, 8'hA0, 1'b1); push(0, 8'hA4, 1'b1);
    push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    exp_push(0, 8'hA0, 0); exp_push(1, 8'hA1, 2); exp_push(2, 8'hA2, 2);
    exp_push(3, 8'hA3, 2); exp_push(0, 8'hA4, 2);
    wait_drain("t2_drain", 30);

    // Almost-full blocks a new grant
    tick();
    fifo_a_full = 1'b1;
    push(1, 8'h61, 1'b1);
    exp_push(1, 8'h61, 0);
    repeat (3) begin
      @(negedge clk);
      check("t3_afull_busy", busy, 0);
    end
    tick();
    fifo_a_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3_busy", busy, 1);
    check("t3_owner", owner, 1);
    wait_drain("t3_drain", 10);

    // Full stalls a beat mid-burst for 3 cycles
    tick();
    push(2, 8'h2A, 1'b0); push(2, 8'h5A, 1'b1);
    exp_push(2, 8'h2A, 0); exp_push(2, 8'h5A, 4);
    @(negedge clk);
    @(negedge clk);
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_ready", req_ready, 0);
      check("t4_wr_en", fifo_write_en, 0);
      check("t4_busy", busy, 1);
      check("t4_owner", owner, 2);
      tick();
    end
    fifo_full = 1'b0;
    wait_drain("t4_drain", 10);
    check("t4_burst_err", burst_err, 0);

    // 10 beats without last until beat 10: forced release after beat 8
    tick();
    for (int b = 0; b < 10; b++) begin
      push(2, 8'h80 + 8'(b), b == 9);
      exp_push(2, 8'h80 + 8'(b), (b == 0) ? 0 : ((b == 8) ? 2 : 1));
    end
    wait_drain("t5_drain", 40);
    check("t5_burst_err", burst_err, 1);
    repeat (3) @(negedge clk);
    check("t5_burst_err_sticky", burst_err, 1);

    // Reset after beat 2 of 4
    tick();
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b0); push(1, 8'hC3, 1'b0); push(1, 8'hC4, 1'b1);
    exp_push(1, 8'hC1, 0); exp_push(1, 8'hC2, 1);
    repeat (3) @(negedge clk);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_wr_en", fifo_write_en, 0);
    check("t6_rst_ready", req_ready, 0);
    tick();
    flush_sources();
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_burst_err", burst_err, 0);
    check("t6_wr_en", fifo_write_en, 0);
    tick();
    reset = 1'b0;
    push(3, 8'hD3, 1'b1); push(1, 8'hD1, 1'b1); push(0, 8'hD0, 1'b1);
    exp_push(0, 8'hD0, 0); exp_push(1, 8'hD1, 2); exp_push(3, 8'hD3, 2);
    wait_drain("t6_drain", 20);

    repeat (4) @(negedge clk);
    check("final_busy", busy, 0);
    check("final_scoreboard", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
